// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives PC into a combinational instruction memory and
// hands fetched words to decode through a valid/ready fetch/decode register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] Instruction,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        dec_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  // One bit wider than the word index so MEM_WORDS = 2^30 still compares correctly.
  localparam logic [30:0] MEM_LIMIT = 31'(MEM_WORDS);

  state_t      state, state_next;
  logic [31:0] pc_next;
  logic [31:0] instr_out_next;
  logic [31:0] instr_pc_next;
  logic        valid_next;
  logic        fault_next;
  logic [15:0] count_next;

  logic advance;
  logic handshake;
  logic pc_in_range;
  logic target_aligned;

  assign advance        = !instr_valid || dec_ready;
  assign handshake      = instr_valid && dec_ready;
  assign pc_in_range    = {1'b0, PC[31:2]} < MEM_LIMIT;
  assign target_aligned = branch_target[1:0] == 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= START;
      PC          <= RESET_PC;
      instr_out   <= 32'h0;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= 16'h0;
    end else begin
      state       <= state_next;
      PC          <= pc_next;
      instr_out   <= instr_out_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= valid_next;
      fetch_fault <= fault_next;
      fetch_count <= count_next;
    end
  end

  // A redirect outranks both advance and stall; bad addresses park the stage in FAULT.
  always_comb begin
    state_next     = state;
    pc_next        = PC;
    instr_out_next = instr_out;
    instr_pc_next  = instr_pc;
    valid_next     = instr_valid;
    fault_next     = fetch_fault;
    count_next     = fetch_count;

    case (state)
      START: begin
        state_next = RUN;
        if (branch_taken) begin
          pc_next = branch_target;
        end
      end

      RUN: begin
        if (handshake) begin
          count_next = fetch_count + 16'd1;
        end
        if (branch_taken) begin
          pc_next    = branch_target;
          valid_next = 1'b0;
          if (!target_aligned) begin
            fault_next = 1'b1;
            state_next = FAULT;
          end
        end else if (advance) begin
          if (!pc_in_range) begin
            valid_next = 1'b0;
            fault_next = 1'b1;
            state_next = FAULT;
          end else begin
            instr_out_next = Instruction;
            instr_pc_next  = PC;
            valid_next     = 1'b1;
            pc_next        = PC + 32'd4;
          end
        end
      end

      FAULT: begin
        valid_next = 1'b0;
      end

      default: begin
        valid_next = 1'b0;
        state_next = FAULT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner
// sequences and randomized traffic compared against a behavioural model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc, instruction, branch_target, instr_out, instr_pc;
  logic        branch_taken, dec_ready, instr_valid, fetch_fault;
  logic [15:0] fetch_count;

  logic [31:0] s_pc, s_instruction, s_out, s_opc;
  logic        s_ready, s_valid, s_fault;
  logic [15:0] s_count;

  logic [31:0] mem [256];

  assign instruction   = (pc[31:10] == 22'h0)   ? mem[pc[9:2]]   : 32'hDEAD_BEEF;
  assign s_instruction = (s_pc[31:10] == 22'h0) ? mem[s_pc[9:2]] : 32'hDEAD_BEEF;

  fetch_unit dut (
    .clk(clk), .reset(reset), .PC(pc), .Instruction(instruction),
    .branch_taken(branch_taken), .branch_target(branch_target), .dec_ready(dec_ready),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(4)) dut_small (
    .clk(clk), .reset(reset), .PC(s_pc), .Instruction(s_instruction),
    .branch_taken(1'b0), .branch_target(32'h0), .dec_ready(s_ready),
    .instr_out(s_out), .instr_pc(s_opc), .instr_valid(s_valid),
    .fetch_fault(s_fault), .fetch_count(s_count)
  );

  int tests = 0;
  int failures = 0;

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        valid;
    logic [31:0] out;
    logic [31:0] opc;
    logic [31:0] pc;
    logic [15:0] count;
    logic        fault;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a fetch pointer, a one-entry output slot and a counter.
  logic [31:0] m_pc, m_out, m_opc;
  logic        m_valid, m_fault, m_started;
  int unsigned m_count;
  int unsigned m_words = 256;

  task automatic model_reset();
    m_pc = 32'h0; m_out = 32'h0; m_opc = 32'h0;
    m_valid = 1'b0; m_fault = 1'b0; m_started = 1'b0; m_count = 0;
  endtask

  task automatic model_step(input logic br, input logic [31:0] tgt, input logic rdy);
    if (m_fault) return;
    if (!m_started) begin
      m_started = 1'b1;
      if (br) m_pc = tgt;
      return;
    end
    if (m_valid && rdy) m_count = (m_count + 1) % 65536;
    if (br) begin
      m_pc = tgt;
      m_valid = 1'b0;
      if (tgt % 4 != 0) m_fault = 1'b1;
    end else if (!m_valid || rdy) begin
      if (m_pc / 4 >= m_words) begin
        m_fault = 1'b1;
        m_valid = 1'b0;
      end else begin
        m_out = mem[m_pc / 4];
        m_opc = m_pc;
        m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic br, input logic [31:0] tgt, input logic rdy);
    branch_taken  = br;
    branch_target = tgt;
    dec_ready     = rdy;
    model_step(br, tgt, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    checkOutput({tag, " valid"}, 32'(instr_valid), 32'(m_valid));
    checkOutput({tag, " pc"},    pc,               m_pc);
    checkOutput({tag, " fault"}, 32'(fetch_fault), 32'(m_fault));
    checkOutput({tag, " count"}, 32'(fetch_count), m_count);
    if (m_valid) begin
      checkOutput({tag, " instr_out"}, instr_out, m_out);
      checkOutput({tag, " instr_pc"},  instr_pc,  m_opc);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, " pc"},    pc,               32'h0);
    checkOutput({tag, " out"},   instr_out,        32'h0);
    checkOutput({tag, " ipc"},   instr_pc,         32'h0);
    checkOutput({tag, " valid"}, 32'(instr_valid), 32'h0);
    checkOutput({tag, " fault"}, 32'(fetch_fault), 32'h0);
    checkOutput({tag, " count"}, 32'(fetch_count), 32'h0);
  endtask

  task automatic add_vec(input logic br, input logic [31:0] tgt, input logic rdy,
                         input logic v, input logic [31:0] o, input logic [31:0] op,
                         input logic [31:0] p, input logic [15:0] c, input logic f);
    vec_t e;
    e.br = br; e.tgt = tgt; e.rdy = rdy; e.valid = v; e.out = o; e.opc = op;
    e.pc = p; e.count = c; e.fault = f;
    vecs.push_back(e);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] tgt;
    int unsigned r;

    branch_taken = 1'b0; branch_target = 32'h0; dec_ready = 1'b1; s_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'hE3A00003; mem[1] = 32'hE3500000; mem[2] = 32'h0A000002;
    mem[3] = 32'hE2400001; mem[4] = 32'hEAFFFFFC; mem[5] = 32'hE3A0102A;
    model_reset();

    // Free-run, stall, branch during stall, misaligned branch and frozen fault state.
    add_vec(0, 0,     1, 0, 0, 0, 32'h00, 0, 0);
    add_vec(0, 0,     1, 1, 32'hE3A00003, 32'h00, 32'h04, 0, 0);
    add_vec(0, 0,     1, 1, 32'hE3500000, 32'h04, 32'h08, 1, 0);
    add_vec(0, 0,     1, 1, 32'h0A000002, 32'h08, 32'h0C, 2, 0);
    add_vec(0, 0,     1, 1, 32'hE2400001, 32'h0C, 32'h10, 3, 0);
    add_vec(0, 0,     0, 1, 32'hE2400001, 32'h0C, 32'h10, 3, 0);
    add_vec(0, 0,     0, 1, 32'hE2400001, 32'h0C, 32'h10, 3, 0);
    add_vec(0, 0,     0, 1, 32'hE2400001, 32'h0C, 32'h10, 3, 0);
    add_vec(0, 0,     1, 1, 32'hEAFFFFFC, 32'h10, 32'h14, 4, 0);
    add_vec(0, 0,     1, 1, 32'hE3A0102A, 32'h14, 32'h18, 5, 0);
    add_vec(0, 0,     1, 1, 32'h10000006, 32'h18, 32'h1C, 6, 0);
    add_vec(0, 0,     0, 1, 32'h10000006, 32'h18, 32'h1C, 6, 0);
    add_vec(1, 32'h4, 0, 0, 0, 0, 32'h04, 6, 0);
    add_vec(0, 0,     1, 1, 32'hE3500000, 32'h04, 32'h08, 6, 0);
    add_vec(0, 0,     1, 1, 32'h0A000002, 32'h08, 32'h0C, 7, 0);
    add_vec(1, 32'h6, 1, 0, 0, 0, 32'h06, 8, 1);
    add_vec(1, 32'h20, 1, 0, 0, 0, 32'h06, 8, 1);
    add_vec(0, 0,     0, 0, 0, 0, 32'h06, 8, 1);
    add_vec(1, 32'h0, 1, 0, 0, 0, 32'h06, 8, 1);

    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].br, vecs[i].tgt, vecs[i].rdy);
      checkOutput($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(vecs[i].valid));
      checkOutput($sformatf("vec%0d pc", i),    pc,               vecs[i].pc);
      checkOutput($sformatf("vec%0d count", i), 32'(fetch_count), 32'(vecs[i].count));
      checkOutput($sformatf("vec%0d fault", i), 32'(fetch_fault), 32'(vecs[i].fault));
      if (vecs[i].valid) begin
        checkOutput($sformatf("vec%0d instr_out", i), instr_out, vecs[i].out);
        checkOutput($sformatf("vec%0d instr_pc", i),  instr_pc,  vecs[i].opc);
      end
    end
    branch_taken = 1'b0;

    // Asynchronous reset asserted between edges while a live instruction is held.
    pulse_reset();
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1);
    checkOutput("pre-async valid", 32'(instr_valid), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async");
    @(posedge clk);
    #1;
    check_reset_values("async held");
    #2;
    reset = 1'b1;
    model_reset();
    applyStimulus(0, 0, 1);
    checkOutput("post-reset start valid", 32'(instr_valid), 32'h0);
    checkOutput("post-reset start pc",    pc,               32'h0);
    applyStimulus(0, 0, 1);
    checkOutput("post-reset first valid", 32'(instr_valid), 32'h1);
    checkOutput("post-reset first out",   instr_out,        32'hE3A00003);
    checkOutput("post-reset first pc",    pc,               32'h4);

    // Out-of-range fault on the 4-word instance.
    s_ready = 1'b1;
    pulse_reset();
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 0, 1);
      if (k == 1) begin
        checkOutput("small start valid", 32'(s_valid), 32'h0);
        checkOutput("small start pc",    s_pc,         32'h0);
      end else if (k <= 5) begin
        checkOutput($sformatf("small k%0d valid", k), 32'(s_valid), 32'h1);
        checkOutput($sformatf("small k%0d out", k),   s_out,        mem[k-2]);
        checkOutput($sformatf("small k%0d ipc", k),   s_opc,        32'((k-2)*4));
        checkOutput($sformatf("small k%0d count", k), 32'(s_count), 32'(k-2));
        checkOutput($sformatf("small k%0d fault", k), 32'(s_fault), 32'h0);
      end else begin
        checkOutput($sformatf("small k%0d valid", k), 32'(s_valid), 32'h0);
        checkOutput($sformatf("small k%0d fault", k), 32'(s_fault), 32'h1);
        checkOutput($sformatf("small k%0d pc", k),    s_pc,         32'h10);
        checkOutput($sformatf("small k%0d count", k), 32'(s_count), 32'h4);
      end
    end

    // Randomized traffic against the reference model.
    for (int run = 0; run < 4; run++) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      pulse_reset();
      for (int c = 0; c < 150; c++) begin
        r = $urandom_range(0, 39);
        if (r == 0)      tgt = 32'($urandom_range(0, 1023)) | 32'h2;
        else if (r == 1) tgt = 32'h3F0 + 32'($urandom_range(0, 3) * 4);
        else if (r == 2) tgt = 32'h800;
        else             tgt = 32'($urandom_range(0, 255) * 4);
        applyStimulus(($urandom_range(0, 9) == 0), tgt, ($urandom_range(0, 3) != 0));
        check_model($sformatf("rand%0d.%0d", run, c));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
